// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, field positions and exception codes.
// Used by cp0_unit and the optional cp0_timer (CP0_TIMER_EN builds).
package cp0_unit_pkg;

    localparam int EXC_CODE_LEN = 5;

    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_INT  = 5'd0;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_ADES = 5'd5;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_RI   = 5'd10;
    localparam logic [EXC_CODE_LEN-1:0] EXC_CODE_OV   = 5'd12;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_SR      = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;

    localparam int SR_IE_BIT    = 0;
    localparam int SR_EXL_BIT   = 1;
    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD_BIT = 31;

    // EPC always holds a word address.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky pending flag; only instantiated when
// CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_pending
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_pending;
    logic [31:0] w_count_inc;

    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_compare <= '0;
            r_pending <= 1'b0;
        end else begin
            r_count <= i_count_we ? i_wdata : w_count_inc;
            // A Compare write clears pending even if the increment hits the old value.
            if (i_compare_we) begin
                r_compare <= i_wdata;
                r_pending <= 1'b0;
            end else if (!i_count_we && (w_count_inc == r_compare)) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_pending = r_pending;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 in the M stage: SR/Cause/EPC/PRId, exception/interrupt entry, eret.
// Optional Count/Compare timer enabled by the CP0_TIMER_EN macro.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h4442_4F53,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [4:0]              addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    input  logic [31:0]             pc_m,
    input  logic                    bd_m,
    input  logic [EXC_CODE_LEN-1:0] exc_in,
    input  logic [5:0]              hw_int,
    input  logic                    eret,
    output logic                    int_req,
    output logic [31:0]             epc,
    output logic [31:0]             handler_pc
);

    logic [5:0]              r_sr_im;
    logic                    r_sr_exl;
    logic                    r_sr_ie;
    logic                    r_cause_bd;
    logic [5:0]              r_cause_ip;
    logic [EXC_CODE_LEN-1:0] r_cause_exc;
    logic [31:0]             r_epc;

    logic [5:0]              w_ip;
    logic                    w_irq;
    logic                    w_exc;
    logic                    w_take;
    logic                    w_wr_en;
    logic [EXC_CODE_LEN-1:0] w_code;
    logic [31:0]             w_entry_epc;
    logic [31:0]             w_sr_word;
    logic [31:0]             w_cause_word;

`ifdef CP0_TIMER_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_timer_pend;
    logic        w_count_we;
    logic        w_compare_we;

    assign w_count_we   = w_wr_en && (addr == CP0_REG_COUNT);
    assign w_compare_we = w_wr_en && (addr == CP0_REG_COMPARE);

    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_count_we   (w_count_we),
        .i_compare_we (w_compare_we),
        .i_wdata      (wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_pending    (w_timer_pend)
    );

    // The timer owns interrupt line 5; the external pin is ignored.
    assign w_ip = {w_timer_pend, hw_int[4:0]};
`else
    assign w_ip = hw_int;
`endif

    assign w_irq   = (|(w_ip & r_sr_im)) && r_sr_ie && !r_sr_exl;
    assign w_exc   = (exc_in != '0) && !r_sr_exl;
    assign w_take  = !reset && (w_irq || w_exc);
    assign w_code  = w_irq ? EXC_CODE_INT : exc_in;
    assign w_wr_en = we && !w_take;

    assign w_entry_epc = align_word(bd_m ? (pc_m - 32'd4) : pc_m);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
        end else begin
            r_cause_ip <= w_ip;
            if (w_take) begin
                // Entry cancels the M instruction, so any mtc0 or eret with it is dropped.
                r_sr_exl    <= 1'b1;
                r_cause_exc <= w_code;
                r_cause_bd  <= bd_m;
                r_epc       <= w_entry_epc;
            end else begin
                if (eret) begin
                    r_sr_exl <= 1'b0;
                end else if (we && (addr == CP0_REG_SR)) begin
                    r_sr_im  <= wdata[SR_IM_HI:SR_IM_LO];
                    r_sr_exl <= wdata[SR_EXL_BIT];
                    r_sr_ie  <= wdata[SR_IE_BIT];
                end
                if (we && (addr == CP0_REG_EPC)) begin
                    r_epc <= align_word(wdata);
                end
            end
        end
    end

    always_comb begin
        w_sr_word                       = '0;
        w_sr_word[SR_IM_HI:SR_IM_LO]    = r_sr_im;
        w_sr_word[SR_EXL_BIT]           = r_sr_exl;
        w_sr_word[SR_IE_BIT]            = r_sr_ie;
        w_cause_word                    = '0;
        w_cause_word[CAUSE_BD_BIT]      = r_cause_bd;
        w_cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = r_cause_ip;
        w_cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = r_cause_exc;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            CP0_REG_SR:      rdata = w_sr_word;
            CP0_REG_CAUSE:   rdata = w_cause_word;
            CP0_REG_EPC:     rdata = r_epc;
            CP0_REG_PRID:    rdata = PRID;
`ifdef CP0_TIMER_EN
            CP0_REG_COUNT:   rdata = w_count;
            CP0_REG_COMPARE: rdata = w_compare;
`endif
            default:         rdata = '0;
        endcase
    end

    assign int_req    = w_take;
    assign epc        = r_epc;
    assign handler_pc = HANDLER_PC;

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 block in the memory stage; the consumer of the execute stage's exception code and the source of its int_req.
- Holds SR, Cause, EPC and PRId.
- Decides each cycle whether the instruction in M is pre-empted by an exception or interrupt, latches its state, and supplies the EPC for eret.
- Serves mfc0/mtc0 reads and writes.

Parameters:
- PRID, 32'h4442_4F53, read-only value of PRId (reg 15).
- HANDLER_PC, 32'h0000_4180, exception vector driven on handler_pc.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- we  in  1  mtc0 write strobe (M stage)
- addr  in  5  CP0 register number for read/write
- wdata  in  32  mtc0 data
- rdata  out  32  mfc0 data, combinational from addr
- pc_m  in  32  PC of the instruction in M
- bd_m  in  1  instruction in M is in a branch-delay slot
- exc_in  in  EXC_CODE_LEN  merged exception code of the M instruction; 0 means none
- hw_int  in  6  external interrupt lines, level-sensitive
- eret  in  1  eret in M
- int_req  out  1  take exception/interrupt this cycle, combinational
- epc  out  32  current EPC, to the PC mux for eret
- handler_pc  out  32  constant HANDLER_PC

Behaviour:
- Register map:
  - SR (12): IM = [15:10], EXL = [1], IE = [0]; all other bits read 0.
  - Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]; all other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): constant PRID.
  - Any other addr reads 0. Writes to Cause, PRId or unmapped addresses are ignored.
- Reset: SR, Cause and EPC go to 0; int_req is 0 while reset is high.
- Cause.IP is sampled from hw_int on every clock edge, regardless of all other events.
- Request decode:
  - irq = |(hw_int & SR.IM) & SR.IE & !SR.EXL
  - exc = exc_in != 0 & !SR.EXL
  - int_req = !reset & (irq | exc)
  - No request is taken while EXL = 1.
- Priority: an interrupt beats a synchronous exception. On an interrupt ExcCode = EXC_CODE_INT (0); otherwise ExcCode = exc_in.
- Entry, on the clock edge where int_req = 1:
  - SR.EXL <= 1
  - Cause.ExcCode <= the selected code
  - Cause.BD <= bd_m
  - EPC <= bd_m ? pc_m - 4 : pc_m, 32-bit wraparound, then bits [1:0] forced to 0.
- Simultaneous events on one edge:
  - int_req and we: the mtc0 write is discarded, because the instruction is cancelled.
  - int_req and eret: the eret is discarded; entry wins.
  - eret without int_req: SR.EXL <= 0, all other fields unchanged.
  - we and eret together cannot arise (one M instruction); if both are asserted, eret has priority for SR and the write to other registers proceeds.
- mtc0 write, when we = 1 and int_req = 0:
  - addr 12: IM, EXL and IE are taken from wdata.
  - addr 14: EPC <= wdata with bits [1:0] forced to 0.
  - The write is visible on rdata from the next cycle; there is no internal read-after-write bypass.
- epc output equals the EPC register, so an mtc0 EPC followed by eret uses the new value.
- Latency: int_req and rdata are zero-cycle; register updates take effect at the next edge.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined:
  - Adds Count (reg 9, +1 every cycle, wraps at 2^32) and Compare (reg 11), both read/write and reset to 0.
  - When Count == Compare after an increment, a sticky timer-pending bit is set; it replaces hw_int[5] in the IP sample and in the irq term.
  - An mtc0 to Compare clears the pending bit.
  - An mtc0 to Count loads wdata in place of that cycle's increment.
- When undefined: regs 9 and 11 read 0 and ignore writes; hw_int[5] is used unchanged.

Decomposition:
- Shared def.v gains:
  - CP0_REG_SR/CAUSE/EPC/PRID/COUNT/COMPARE numbers
  - SR/Cause bit-position constants
  - EXC_CODE_INT/ADEL/ADES/RI/OV codes, alongside the existing EXC_CODE_LEN and EXC_CODE_OV
- Optional sub-module cp0_timer (Count/Compare/pending), instantiated only under CP0_TIMER_EN; everything else stays flat.

Test Plan:
- Reset, then read addr 12/13/14/15 -> rdata 0, 0, 0, PRID; int_req = 0 even with exc_in = OV during reset.
- Overflow in a non-delay slot:
  - Stimulus: exc_in = EXC_CODE_OV, pc_m = 0x3010, bd_m = 0.
  - Response: int_req = 1 that cycle; next cycle EPC = 0x3010, Cause[6:2] = 12, BD = 0, SR.EXL = 1; a second exc_in = OV now gives int_req = 0.
- Interrupt in a delay slot:
  - Stimulus: mtc0 SR = 0x0000_0401, then hw_int = 6'b000001, bd_m = 1, pc_m = 0x3020, exc_in = RI in the same cycle.
  - Response: int_req = 1; EPC = 0x301C, ExcCode = 0, BD = 1, IP[10] = 1.
- Write racing entry:
  - Stimulus: we = 1, addr = 14, wdata = 0x1234 with exc_in = OV, pc_m = 0x3040.
  - Response: EPC = 0x3040, not 0x1234.
- mtc0 EPC then eret:
  - Stimulus: with EXL = 1, mtc0 EPC = 0x3007, then eret.
  - Response: epc = 0x3004; EXL = 0 after the eret edge; Cause unchanged.
- CP0_TIMER_EN:
  - Stimulus: SR = 0x0000_8001, Compare = 20, Count = 0.
  - Response: int_req = 1 once Count = 20; after an mtc0 Compare = 100 the pending bit clears.
